// File: rtl/foo_tb_stim_drv.sv
// Stimulus driver for the foo test path: buffers bench-loaded bytes and replays them as test_in beats.
// Latency: start accepted at edge N gives the first registered beat at edge N+1; the gap setting adds idle cycles between beats.
// Backpressure: load_ready drops while the FIFO is full; the beat side has no ready and always drives.
// Optional feature: define FOO_TB_DRV_CHECKSUM_EN to append a mod-256 checksum beat after each burst.
module foo_tb_stim_drv #(
   parameter int DEPTH = 16,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [7:0]       load_data,
   output logic             load_ready,
   input  logic [GAP_W-1:0] gap,
   input  logic             start,
   output logic             busy,
   output logic             test_in_valid,
   output logic [7:0]       test_in,
   output logic [15:0]      sent_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP
`ifdef FOO_TB_DRV_CHECKSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t           state_q;
   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic             valid_q;
   logic [7:0]       data_q;
   logic [15:0]      sent_q;
`ifdef FOO_TB_DRV_CHECKSUM_EN
   logic [7:0]       sum_q;
`endif

   logic push;
   logic pop;
   logic fifo_empty;
   logic last_pop;

   assign load_ready    = (count_q != FULL_CNT);
   assign push          = load_valid && load_ready;
   // SEND is only entered with data queued, so a pop there never underflows
   assign pop           = (state_q == S_SEND);
   assign fifo_empty    = (count_q == '0);
   // A push landing in the same cycle as the final pop keeps the burst alive
   assign last_pop      = (count_q == ONE_CNT) && !push;

   assign busy          = (state_q != S_IDLE);
   assign test_in_valid = valid_q;
   assign test_in       = data_q;
   assign sent_count    = sent_q;

   // FIFO occupancy next-state from simultaneous push/pop
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // FIFO storage; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= load_data;
      end
   end

   // FIFO pointers and occupancy; reset flushes queued data
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Burst FSM with registered beat outputs and beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         valid_q   <= 1'b0;
         data_q    <= 8'h00;
         sent_q    <= 16'h0000;
         gap_q     <= '0;
         gap_cnt_q <= '0;
`ifdef FOO_TB_DRV_CHECKSUM_EN
         sum_q     <= 8'h00;
`endif
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !fifo_empty) begin
                  state_q <= S_SEND;
                  gap_q   <= gap;
`ifdef FOO_TB_DRV_CHECKSUM_EN
                  sum_q   <= 8'h00;
`endif
               end
            end
            S_SEND: begin
               valid_q <= 1'b1;
               data_q  <= mem_q[rd_ptr_q];
               sent_q  <= sent_q + 16'd1;
`ifdef FOO_TB_DRV_CHECKSUM_EN
               sum_q   <= sum_q + mem_q[rd_ptr_q];
`endif
               if (last_pop) begin
`ifdef FOO_TB_DRV_CHECKSUM_EN
                  if (gap_q != '0) begin
                     state_q   <= S_GAP;
                     gap_cnt_q <= gap_q - 1'b1;
                  end else begin
                     state_q <= S_CSUM;
                  end
`else
                  state_q <= S_IDLE;
`endif
               end else if (gap_q == '0) begin
                  state_q <= S_SEND;
               end else begin
                  // Counter runs gap_q-1 down to 0, giving exactly gap_q idle cycles
                  state_q   <= S_GAP;
                  gap_cnt_q <= gap_q - 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt_q != '0) begin
                  gap_cnt_q <= gap_cnt_q - 1'b1;
               end else if (!fifo_empty) begin
                  state_q <= S_SEND;
               end else begin
`ifdef FOO_TB_DRV_CHECKSUM_EN
                  state_q <= S_CSUM;
`else
                  state_q <= S_IDLE;
`endif
               end
            end
`ifdef FOO_TB_DRV_CHECKSUM_EN
            S_CSUM: begin
               // Checksum beat is not a data beat, so sent_q is left alone
               valid_q <= 1'b1;
               data_q  <= sum_q;
               state_q <= S_IDLE;
            end
`endif
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_foo_tb_stim_drv.sv
// Bench for foo_tb_stim_drv: directed loads/starts, expected beats queued at stimulus time.
// A negedge monitor pops and compares every valid beat; timing and status checks run inline.
module tb_foo_tb_stim_drv;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_valid;
   logic [7:0]  load_data;
   logic        load_ready;
   logic [3:0]  gap;
   logic        start;
   logic        busy;
   logic        test_in_valid;
   logic [7:0]  test_in;
   logic [15:0] sent_count;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_q [$];

   foo_tb_stim_drv #(.DEPTH(16), .GAP_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .gap           (gap),
      .start         (start),
      .busy          (busy),
      .test_in_valid (test_in_valid),
      .test_in       (test_in),
      .sent_count    (sent_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every valid beat must match the oldest expected byte
   always @(negedge clk) begin
      if (test_in_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {24'h0, test_in}, 32'hFFFF_FFFF);
         end else begin
            chk("beat_data", {24'h0, test_in}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      load_valid = 1'b1;
      load_data  = b;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] g);
      gap   = g;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load_valid = 1'b0; load_data = 8'h00; gap = 4'd0; start = 1'b0;

      // 1: reset state
      tick(); tick();
      chk("rst_valid",      {31'h0, test_in_valid}, 32'd0);
      chk("rst_test_in",    {24'h0, test_in},       32'h00);
      chk("rst_busy",       {31'h0, busy},          32'd0);
      chk("rst_sent_count", {16'h0, sent_count},    32'd0);
      chk("rst_load_ready", {31'h0, load_ready},    32'd1);
      reset = 1'b0;
      tick();

      // 2: back-to-back burst
      load_byte(8'h11); load_byte(8'h22); load_byte(8'h33);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
      do_start(4'd0);
      chk("t2_busy_after_start", {31'h0, busy}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_valid_run", {31'h0, test_in_valid}, 32'd1);
      end
      tick();
      chk("t2_valid_end", {31'h0, test_in_valid}, 32'd0);
      chk("t2_busy_end",  {31'h0, busy},          32'd0);
      chk("t2_sent",      {16'h0, sent_count},    32'd3);
      chk("t2_hold_data", {24'h0, test_in},       32'h33);

      // 3: gap of 2 between beats -> 1,0,0,1
      load_byte(8'hA5); load_byte(8'h5A);
      exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
      do_start(4'd2);
      begin
         logic [3:0] pat;
         pat = 4'b1001;
         for (int i = 3; i >= 0; i--) begin
            tick();
            chk("t3_valid_pattern", {31'h0, test_in_valid}, {31'h0, pat[i]});
         end
      end
      tick();
      chk("t3_busy_end", {31'h0, busy},       32'd0);
      chk("t3_sent",     {16'h0, sent_count}, 32'd5);

      // 4: fill to full, 17th load refused, then drain in order
      for (int i = 0; i < 16; i++) begin
         load_byte(8'(i));
         exp_q.push_back(8'(i));
      end
      chk("t4_full_ready", {31'h0, load_ready}, 32'd0);
      load_byte(8'h10);
      chk("t4_ready_after_17th", {31'h0, load_ready}, 32'd0);
      do_start(4'd0);
      for (int i = 0; i < 18; i++) tick();
      chk("t4_sent",       {16'h0, sent_count}, 32'd21);
      chk("t4_ready_back", {31'h0, load_ready}, 32'd1);
      chk("t4_busy_end",   {31'h0, busy},       32'd0);

      // 5: reset after two beats discards the rest
      for (int i = 0; i < 5; i++) load_byte(8'hC0 + 8'(i));
      exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
      do_start(4'd0);
      tick();
      tick();
      chk("t5_second_beat", {31'h0, test_in_valid}, 32'd1);
      reset = 1'b1;
      tick();
      chk("t5_valid_drop", {31'h0, test_in_valid}, 32'd0);
      chk("t5_sent_clr",   {16'h0, sent_count},    32'd0);
      chk("t5_busy",       {31'h0, busy},          32'd0);
      chk("t5_ready",      {31'h0, load_ready},    32'd1);
      reset = 1'b0;
      tick();
      do_start(4'd0);
      chk("t5_start_empty_busy", {31'h0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("t5_no_beats", {16'h0, sent_count}, 32'd0);

`ifdef FOO_TB_DRV_CHECKSUM_EN
      // 6: checksum beat 80+90 = 10 (mod 256) right after the data
      load_byte(8'h80); load_byte(8'h90);
      exp_q.push_back(8'h80); exp_q.push_back(8'h90); exp_q.push_back(8'h10);
      do_start(4'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_valid_run", {31'h0, test_in_valid}, 32'd1);
      end
      tick();
      chk("t6_valid_end", {31'h0, test_in_valid}, 32'd0);
      chk("t6_sent",      {16'h0, sent_count},    32'd2);
      chk("t6_busy_end",  {31'h0, busy},          32'd0);
`endif

      for (int i = 0; i < 4; i++) tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
